fsm_cmd_arbiter: RTL

Input scheduler in front of the lab FSM. Captures rising edges on four pushbutton/switch request lines, holds each as a pending request, and issues them to the FSM one at a time as single-cycle one-hot commands. A programmable minimum gap between issued commands gives the FSM settle time. Sits between the board switches and the FSM command inputs, clocked from the same KEY0 clock.

---
 rtl/fsm_cmd_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fsm_cmd_arbiter.sv
// fsm_cmd_arbiter: captures rising edges on four request lines (SW1..SW4),
// holds each one as a pending request, and issues the requests to the lab FSM
// one at a time as single-cycle one-hot commands. After each command the
// arbiter waits a programmable number of idle cycles (GAP) before the next one.
//
// Optional feature macro: FSM_ARB_RR_EN
//   defined     -> round-robin selection, starting after the last issued channel
//   not defined -> fixed priority, channel 0 (SW1) highest, channel 3 (SW4) lowest
//
// Handshake: there is no ready. cmd_valid is high for exactly one cycle per
// issued command, and in that cycle cmd carries a one-hot channel code. In every
// other cycle both are zero. The FSM must accept a command in the cycle it is shown.
module fsm_cmd_arbiter #(
    parameter int GAP   = 1,
    parameter int GAP_W = 4
) (
    input  logic       KEY0,
    input  logic       SW0,
    input  logic       SW1,
    input  logic       SW2,
    input  logic       SW3,
    input  logic       SW4,
    output logic [3:0] cmd,
    output logic       cmd_valid,
    output logic [3:0] pending,
    output logic [3:0] ovf,
    output logic       gap_busy,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         sw;
    logic [3:0]         prev_q, prev_d;
    logic [3:0]         edge_det;
    logic [3:0]         pending_q, pending_d;
    logic [3:0]         ovf_q, ovf_d;
    logic [3:0]         cmd_q, cmd_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [1:0]         last_q, last_d;
    logic [1:0]         sel;
    logic               sel_found;
    logic               issue;
    logic [3:0]         issue_oh;
`ifdef FSM_ARB_RR_EN
    logic [1:0]         rr_idx;
`endif

    assign sw       = {SW4, SW3, SW2, SW1};
    assign edge_det = sw & ~prev_q;

    // Pick the channel to issue from the registered pending bits only.
    always_comb begin
        sel       = 2'd0;
        sel_found = 1'b0;
`ifdef FSM_ARB_RR_EN
        rr_idx    = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            rr_idx = last_q + 2'(i);
            if (!sel_found && pending_q[rr_idx]) begin
                sel       = rr_idx;
                sel_found = 1'b1;
            end
        end
`else
        for (int i = 3; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel       = 2'(i);
                sel_found = 1'b1;
            end
        end
`endif
    end

    // Issue decision and next values of all registered state.
    always_comb begin
        issue       = sel_found && (gap_cnt_q == '0);
        issue_oh    = issue ? (4'b0001 << sel) : 4'b0000;
        prev_d      = sw;
        // A same-edge re-request on the issued channel re-arms it without overflow.
        pending_d   = (pending_q & ~issue_oh) | edge_det;
        ovf_d       = ovf_q | (edge_det & pending_q & ~issue_oh);
        cmd_d       = issue_oh;
        cmd_valid_d = issue;
        last_d      = issue ? sel : last_q;
        if (issue) begin
            gap_cnt_d = GAP_W'(GAP);
        end else if (gap_cnt_q != '0) begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end else begin
            gap_cnt_d = gap_cnt_q;
        end
    end

    // Next-state logic for the IDLE / ISSUE / GAP view of the arbiter.
    always_comb begin
        state_d = ST_IDLE;
        if (issue) begin
            state_d = ST_ISSUE;
        end else if (gap_cnt_d != '0) begin
            state_d = ST_GAP;
        end
    end

    // State register; the line history follows the inputs even during reset.
    always_ff @(posedge KEY0) begin
        prev_q <= prev_d;
        if (SW0) begin
            state_q     <= ST_IDLE;
            pending_q   <= 4'b0000;
            ovf_q       <= 4'b0000;
            cmd_q       <= 4'b0000;
            cmd_valid_q <= 1'b0;
            gap_cnt_q   <= '0;
            last_q      <= 2'd3;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            ovf_q       <= ovf_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            gap_cnt_q   <= gap_cnt_d;
            last_q      <= last_d;
        end
    end

    // Outputs are driven straight from registers.
    always_comb begin
        cmd       = cmd_q;
        cmd_valid = cmd_valid_q;
        pending   = pending_q;
        ovf       = ovf_q;
        gap_busy  = (gap_cnt_q != '0);
        state_dbg = state_q;
    end

endmodule
